// File: rtl/direction_controller.sv
// Push-button to snake direction: 2-FF sync, per-button debounce, press detect, 2-deep turn queue committed on tick.
// Press lands in the queue 2+DEBOUNCE_CYCLES+1 cycles after the btn_n edge; REVERSE_BLOCK_EN enables the 180-degree-turn reject.
module direction_controller #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [1:0] RESET_DIR       = 2'd3
) (
  input  logic       clk50,
  input  logic       resetn,
  input  logic [3:0] btn_n,
  input  logic       tick,
  input  logic       gameOver,
  output logic [1:0] direction,
  output logic [1:0] queue_count,
  output logic       press_drop
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    fall;

  logic       press;
  logic [1:0] pdir;
  logic [1:0] tail;
  logic       reject;
  logic       push;
  logic       drop;
  logic       pop;
  logic [1:0] q0;
  logic [1:0] q1;

  always_ff @(posedge clk50 or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk50 or negedge resetn) begin
    if (!resetn) begin
      deb <= 4'hF;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // The press event is the cycle in which the debounced level is about to fall,
  // so the queue update lands on the same edge as the debounced level.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fall[i] = deb[i] & ~sync2[i] & (db_cnt[i] == CNT_MAX);
    end
  end

  always_comb begin
    press = |fall;
    pdir  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (fall[i]) pdir = 2'(i);
    end
  end

  always_comb begin
    tail = direction;
    if (queue_count == 2'd2)      tail = q1;
    else if (queue_count == 2'd1) tail = q0;
  end

  always_comb begin
    reject = (pdir == tail);
`ifdef REVERSE_BLOCK_EN
    if (pdir == (tail ^ 2'b11)) reject = 1'b1;
`endif
  end

  // The full check uses the pre-pop count, so a tick in the same cycle does not make room.
  assign push = press & ~gameOver & ~reject & (queue_count != 2'd2);
  assign drop = press & ~gameOver & (reject | (queue_count == 2'd2));
  assign pop  = tick & ~gameOver & (queue_count != 2'd0);

  always_ff @(posedge clk50 or negedge resetn) begin
    if (!resetn) begin
      direction   <= RESET_DIR;
      queue_count <= 2'd0;
      press_drop  <= 1'b0;
      q0          <= 2'd0;
      q1          <= 2'd0;
    end else if (gameOver) begin
      queue_count <= 2'd0;
      press_drop  <= 1'b0;
    end else begin
      press_drop <= drop;
      case ({push, pop})
        2'b11: begin
          direction <= q0;
          q0        <= pdir;
        end
        2'b01: begin
          direction   <= q0;
          q0          <= q1;
          queue_count <= queue_count - 2'd1;
        end
        2'b10: begin
          if (queue_count == 2'd0) q0 <= pdir;
          else                     q1 <= pdir;
          queue_count <= queue_count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
